// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default bubble payload for the skid stage
package pipe_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with asynchronous active-low reset
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    // count up on inc, holding at all-ones
    always_ff @(posedge clk or negedge reset)
        if (!reset) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer with registered in_ready and flush; PIPE_SKID_STAGE_PERF_EN adds stall/bubble counters
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_SKID_STAGE_PERF_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
`endif
    output logic [1:0]        occupancy
);
    state_t            state, state_d;
    logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              ready_q, in_fire, out_fire;

    assign in_ready  = ready_q & ~flush;
    assign out_valid = state != ST_EMPTY;
    assign out_data  = main_q;
    assign occupancy = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // state, payload registers and registered ready (low only when both entries are held)
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= ST_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= state_d != ST_TWO;
        end

    // next state and payloads; main reverts to the bubble whenever the stage empties
    always_comb begin
        state_d = state;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else begin
            case (state)
                ST_EMPTY: if (in_fire) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
                ST_ONE: if (in_fire && out_fire) main_d = in_data;
                else if (in_fire) begin
                    state_d = ST_TWO;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_VALUE;
                end
                ST_TWO: if (out_fire) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_VALUE;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STAGE_PERF_EN
    sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );
    sat_counter #(.W(32)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~out_valid),
        .count (bubble_cnt)
    );
`endif
endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (legal range 1..256).
REQ-002 SHALL have parameter NOP_VALUE, default 32'h0000_0000 zero-extended or truncated to DATA_W, bubble payload.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream payload valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept; registered except for the flush gating in REQ-017.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-009 SHALL have port out_valid  output  1  downstream payload valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts.
REQ-011 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-012 SHALL have port occupancy  output  2  held entries, 0..2.

Function
REQ-013 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-014 SHALL implement states EMPTY(0), ONE(1), TWO(2); occupancy equals the state encoding.
REQ-015 SHALL transition: EMPTY + in_fire -> ONE (main<=in_data); ONE + in_fire + out_fire -> ONE (main<=in_data); ONE + in_fire only -> TWO (skid<=in_data); ONE + out_fire only -> EMPTY; TWO + out_fire -> ONE (main<=skid); no change otherwise.
REQ-016 SHALL register in_ready = 1 in EMPTY and ONE, 0 in TWO, so no combinational path from out_ready to in_ready.
REQ-017 SHALL, when flush=1, force in_ready=0 combinationally, discard any in_valid, and on the next edge go to EMPTY with main and skid loaded with NOP_VALUE; flush overrides all other transitions.
REQ-018 SHALL drive out_valid=1 iff state != EMPTY, out_data = main; out_data = NOP_VALUE while out_valid=0.
REQ-019 SHALL give one-cycle latency from in_fire to out_valid and sustain one transfer per cycle with out_ready held high.
REQ-020 SHALL preserve order and never drop or duplicate a payload, except payloads held or presented during flush.
REQ-021 SHALL keep out_data stable while out_valid=1 and out_ready=0.

Reset
REQ-022 SHALL, on reset=0, immediately force state EMPTY, main and skid to NOP_VALUE, out_valid=0, occupancy=0, in_ready=0.
REQ-023 SHALL raise in_ready on the first rising clk edge after reset deasserts; reset asserted mid-transfer discards all held entries.

Configuration
REQ-024 SHALL, with macro PIPE_SKID_STAGE_PERF_EN defined, add outputs stall_cnt[31:0] and bubble_cnt[31:0].
REQ-025 SHALL increment stall_cnt each cycle with out_valid=1 and out_ready=0, and bubble_cnt each cycle with out_valid=0 and reset deasserted.
REQ-026 SHALL make both counters saturate at 32'hFFFF_FFFF, clear them only on reset (not flush), and count a flush cycle by its pre-edge state.
REQ-027 SHALL, without the macro, omit both ports and all counter logic, with identical remaining behaviour.

Structure
REQ-028 SHALL place the state encoding constants (ST_EMPTY, ST_ONE, ST_TWO) and the default NOP constant 32'h0000_0000 in shared package pipe_pkg.
REQ-029 SHALL implement each performance counter as an instance of sub-module sat_counter (width 32, inc, saturating, async active-low reset), present only under PIPE_SKID_STAGE_PERF_EN.

Verification
REQ-030 SHALL cover reset: reset=0 with in_valid=1, in_data=32'h1234 -> out_valid=0, in_ready=0, occupancy=0; in_ready=1 one edge after release.
REQ-031 SHALL cover streaming: out_ready=1, send 32'h1, 32'h2, 32'h3 back-to-back -> out_data 1, 2, 3 on consecutive cycles, each one cycle after input.
REQ-032 SHALL cover backpressure: out_ready=0, send 32'hA, then 32'hB -> occupancy=2, in_ready=0, out_data=32'hA stable; raise out_ready -> A then B, occupancy returns to 0.
REQ-033 SHALL cover flush at occupancy 2 with in_valid=1, in_data=32'hC -> in_ready=0 that cycle; next cycle out_valid=0, out_data=NOP_VALUE; C is never output.
REQ-034 SHALL cover simultaneous in_fire and out_fire in ONE: main=32'h5, send 32'h6 with out_ready=1 -> occupancy stays 1, out_data=32'h6 next cycle.
REQ-035 SHALL cover, with PIPE_SKID_STAGE_PERF_EN defined, 4 cycles out_valid=1 and out_ready=0 -> stall_cnt=4; forced counter value 32'hFFFF_FFFF plus one increment -> stays 32'hFFFF_FFFF.
